// File: rtl/jk_ff.sv
// +--------------------------------------------------------------------------+
// | jk_ff : bank of WIDTH independent positive-edge JK flip-flops with an    |
// |         asynchronous active-high reset and complementary outputs.        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module jk_ff #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_next;

  always_comb begin
    w_next = r_q;
    for (int i = 0; i < WIDTH; i++) begin
      case ({j[i], k[i]})
        2'b00:   w_next[i] = r_q[i];
        2'b01:   w_next[i] = 1'b0;
        2'b10:   w_next[i] = 1'b1;
        default: w_next[i] = ~r_q[i];
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= RESET_VALUE;
    end else begin
      r_q <= w_next;
    end
  end

  // qbar comes from the same register so the outputs can never disagree.
  assign q    = r_q;
  assign qbar = ~r_q;

endmodule

`default_nettype wire

// File: tb/tb_jk_ff.sv
// +--------------------------------------------------------------------------+
// | tb_jk_ff : self-checking bench for jk_ff (WIDTH=1, WIDTH=4, and WIDTH=4  |
// |            with a non-zero reset value) against a behavioural model.     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_jk_ff;

  localparam logic [3:0] C_RV4 = 4'b0101;

  logic       clk;
  logic       rst;
  logic       j1, k1;
  logic [3:0] j4, k4;
  logic       q1, qb1;
  logic [3:0] q4, qb4, q4r, qb4r;

  // behavioural state of each instance
  logic       m1;
  logic [3:0] m4, m4r;

  int n_checks = 0;
  int n_pass   = 0;

  jk_ff u_dut1 (
    .clk   (clk),
    .reset (rst),
    .j     (j1),
    .k     (k1),
    .q     (q1),
    .qbar  (qb1)
  );

  jk_ff #(.WIDTH(4)) u_dut4 (
    .clk   (clk),
    .reset (rst),
    .j     (j4),
    .k     (k4),
    .q     (q4),
    .qbar  (qb4)
  );

  jk_ff #(.WIDTH(4), .RESET_VALUE(C_RV4)) u_dut4r (
    .clk   (clk),
    .reset (rst),
    .j     (j4),
    .k     (k4),
    .q     (q4r),
    .qbar  (qb4r)
  );

  always #5 clk = ~clk;

  // JK truth table applied bit by bit
  function automatic logic [3:0] jk_rule(input logic [3:0] q, input logic [3:0] j,
                                         input logic [3:0] k);
    logic [3:0] r;
    for (int b = 0; b < 4; b++) begin
      if (j[b] && k[b])      r[b] = !q[b];
      else if (j[b])         r[b] = 1'b1;
      else if (k[b])         r[b] = 1'b0;
      else                   r[b] = q[b];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".q1"},    {3'b000, q1},  {3'b000, m1});
    chk({tag, ".qb1"},   {3'b000, qb1}, {3'b000, ~m1});
    chk({tag, ".q4"},    q4,   m4);
    chk({tag, ".qb4"},   qb4,  ~m4);
    chk({tag, ".q4r"},   q4r,  m4r);
    chk({tag, ".qb4r"},  qb4r, ~m4r);
  endtask

  task automatic model_reset();
    m1  = 1'b0;
    m4  = 4'b0000;
    m4r = C_RV4;
  endtask

  // Advance to the next rising edge, update the model, sample 1 unit later.
  task automatic edge_step(input string tag);
    logic [3:0] t;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      t   = jk_rule({3'b000, m1}, {3'b000, j1}, {3'b000, k1});
      m1  = t[0];
      m4  = jk_rule(m4, j4, k4);
      m4r = jk_rule(m4r, j4, k4);
    end
    #1;
    check_all(tag);
  endtask

  task automatic neg_step(input string tag);
    @(negedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b0;
    j1  = 1'b0;  k1 = 1'b0;
    j4  = 4'b0;  k4 = 4'b0;

    // async reset with no clock edge
    #3 rst = 1'b1;
    model_reset();
    #1 check_all("async_rst");

    j1 = 1'b1; k1 = 1'b1; j4 = 4'hF; k4 = 4'hF;
    for (int i = 0; i < 3; i++) edge_step("rst_hold");

    // sweep {j,k,reset}
    for (int c = 0; c < 8; c++) begin
      logic [2:0] code;
      code = c[2:0];
      j1  = code[2];
      k1  = code[1];
      rst = code[0];
      j4  = {4{code[2]}};
      k4  = {4{code[1]}};
      edge_step($sformatf("sweep%0d", c));
    end

    // toggle run, including falling edges
    rst = 1'b0;
    @(negedge clk);
    model_reset();
    rst = 1'b1;
    #1 rst = 1'b0;
    j1 = 1'b1; k1 = 1'b1; j4 = 4'hF; k4 = 4'hF;
    for (int i = 0; i < 4; i++) begin
      edge_step("toggle");
      chk("toggle_seq", {3'b000, q1}, (i % 2 == 0) ? 4'd1 : 4'd0);
      neg_step("toggle_neg");
    end

    // set / hold / clear
    j1 = 1'b1; k1 = 1'b0; j4 = 4'hF; k4 = 4'h0;
    edge_step("set");
    chk("set_q", {3'b000, q1}, 4'd1);
    j1 = 1'b0; k1 = 1'b0; j4 = 4'h0; k4 = 4'h0;
    for (int i = 0; i < 3; i++) edge_step("hold");
    chk("hold_q", {3'b000, q1}, 4'd1);
    j1 = 1'b0; k1 = 1'b1; j4 = 4'h0; k4 = 4'hF;
    edge_step("clear");
    chk("clear_qb", {3'b000, qb1}, 4'd1);

    // mid-cycle reset pulse while toggling
    j1 = 1'b1; k1 = 1'b0; j4 = 4'hF; k4 = 4'h0;
    edge_step("preset");
    j1 = 1'b1; k1 = 1'b1; j4 = 4'hF; k4 = 4'hF;
    @(negedge clk);
    #1 rst = 1'b1;
    model_reset();
    #1 check_all("mid_rst");
    #1 rst = 1'b0;
    edge_step("post_mid_rst");
    chk("post_mid_q", {3'b000, q1}, 4'd1);

    // WIDTH=4 per-bit directed case from reset
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1 rst = 1'b0;
    j4 = 4'b1010; k4 = 4'b0110; j1 = 1'b0; k1 = 1'b0;
    edge_step("w4");
    chk("w4_q",  q4,  4'b1010);
    chk("w4_qb", qb4, 4'b0101);

    // random stimulus against the model
    for (int i = 0; i < 60; i++) begin
      j1  = 1'($urandom);
      k1  = 1'($urandom);
      j4  = 4'($urandom);
      k4  = 4'($urandom);
      rst = ($urandom_range(0, 7) == 0);
      edge_step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
